// File: rtl/clock_set_controller.sv
// Tick prescaler and H/M/S time-set FSM for the 24-hour BCD clock.
// Optional display blinking of the edited field: CLOCK_SET_BLINK_EN.
module clock_set_controller #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Mode_btn,
  input  logic        Inc_btn,
  input  logic        Dec_btn,
  input  logic [23:0] Time_now,
  output logic        Tick,
  output logic        Load,
  output logic [23:0] Time_load,
  output logic [1:0]  Edit_field,
  output logic [2:0]  Blank_mask
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_RUN,
    S_SET_H,
    S_SET_M,
    S_SET_S,
    S_COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [23:0]   r_shadow;
  logic [23:0]   w_shadow;
  logic          r_mode_q;
  logic          r_inc_q;
  logic          r_dec_q;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_idle;
  logic          r_tick;
  logic          r_load;
  logic [1:0]    r_field;

  logic w_mode_e;
  logic w_inc_e;
  logic w_dec_e;
  logic w_any_e;
  logic w_step_inc;
  logic w_step_dec;
  logic w_sec;
  logic w_timeout;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] mx
  );
    if (v == mx) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v,
    input logic [7:0] mx
  );
    if (v == 8'h00) return mx;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      S_SET_H: return 2'd1;
      S_SET_M: return 2'd2;
      S_SET_S: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign w_mode_e   = Mode_btn & ~r_mode_q;
  assign w_inc_e    = Inc_btn & ~r_inc_q;
  assign w_dec_e    = Dec_btn & ~r_dec_q;
  assign w_any_e    = w_mode_e | w_inc_e | w_dec_e;
  // Mode wins over a field step; Inc+Dec together cancel
  assign w_step_inc = w_inc_e & ~w_dec_e & ~w_mode_e;
  assign w_step_dec = w_dec_e & ~w_inc_e & ~w_mode_e;

  assign w_sec     = (r_presc == PW'(TICK_DIV - 1));
  assign w_timeout = w_sec & ~w_any_e &
                     (r_idle == 8'(TIMEOUT_S - 1));

  always_comb begin
    w_next   = r_state;
    w_shadow = r_shadow;
    unique case (r_state)
      S_RUN: begin
        if (w_mode_e) begin
          w_next   = S_SET_H;
          w_shadow = Time_now;
        end
      end
      S_SET_H: begin
        if (w_mode_e) w_next = S_SET_M;
        else if (w_timeout) w_next = S_RUN;
        else if (w_step_inc)
          w_shadow[23:16] = bcd_inc(r_shadow[23:16], 8'h23);
        else if (w_step_dec)
          w_shadow[23:16] = bcd_dec(r_shadow[23:16], 8'h23);
      end
      S_SET_M: begin
        if (w_mode_e) w_next = S_SET_S;
        else if (w_timeout) w_next = S_RUN;
        else if (w_step_inc)
          w_shadow[15:8] = bcd_inc(r_shadow[15:8], 8'h59);
        else if (w_step_dec)
          w_shadow[15:8] = bcd_dec(r_shadow[15:8], 8'h59);
      end
      S_SET_S: begin
        if (w_mode_e) w_next = S_COMMIT;
        else if (w_timeout) w_next = S_RUN;
        else if (w_step_inc)
          w_shadow[7:0] = bcd_inc(r_shadow[7:0], 8'h59);
        else if (w_step_dec)
          w_shadow[7:0] = bcd_dec(r_shadow[7:0], 8'h59);
      end
      S_COMMIT: w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_RUN;
      r_shadow <= 24'h000000;
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
      r_dec_q  <= 1'b0;
      r_presc  <= '0;
      r_idle   <= 8'd0;
      r_tick   <= 1'b0;
      r_load   <= 1'b0;
      r_field  <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_shadow <= w_shadow;
      r_mode_q <= Mode_btn;
      r_inc_q  <= Inc_btn;
      r_dec_q  <= Dec_btn;
      // Restart on commit so the first post-load tick is a full period away
      if (w_sec || w_next == S_COMMIT) r_presc <= '0;
      else r_presc <= r_presc + 1'b1;
      if (w_any_e) r_idle <= 8'd0;
      else if (w_sec && r_idle != 8'(TIMEOUT_S))
        r_idle <= r_idle + 8'd1;
      r_tick  <= w_sec && (w_next == S_RUN);
      r_load  <= (w_next == S_COMMIT);
      r_field <= field_of(w_next);
    end
  end

  assign Tick       = r_tick;
  assign Load       = r_load;
  assign Time_load  = r_shadow;
  assign Edit_field = r_field;

`ifdef CLOCK_SET_BLINK_EN
  localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [HW-1:0] r_blink_cnt;
  logic [2:0]    r_mask;
  logic          w_hold;

  function automatic logic [2:0] field_bit(input state_t s);
    case (s)
      S_SET_H: return 3'b100;
      S_SET_M: return 3'b010;
      S_SET_S: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  assign w_hold = (w_next == r_state) && (field_of(w_next) != 2'd0) &&
                  !(w_inc_e || w_dec_e);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_blink_cnt <= '0;
      r_mask      <= 3'b000;
    end else if (!w_hold) begin
      r_blink_cnt <= '0;
      r_mask      <= 3'b000;
    end else if (r_blink_cnt == HW'(HALF - 1)) begin
      r_blink_cnt <= '0;
      r_mask      <= r_mask ^ field_bit(r_state);
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign Blank_mask = r_mask;
`else
  assign Blank_mask = 3'b000;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller (TICK_DIV=4, TIMEOUT_S=2).
// Load/Time_load are checked by a monitor against queued expectations.
module tb_clock_set_controller;

`ifdef CLOCK_SET_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Mode_btn = 1'b0;
  logic        Inc_btn = 1'b0;
  logic        Dec_btn = 1'b0;
  logic [23:0] Time_now = 24'h0;
  logic        Tick;
  logic        Load;
  logic [23:0] Time_load;
  logic [1:0]  Edit_field;
  logic [2:0]  Blank_mask;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int load_cyc = 0;
  bit load_pend = 1'b0;
  logic [23:0] exp_q[$];

  clock_set_controller #(
    .TICK_DIV (4),
    .TIMEOUT_S(2)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Mode_btn  (Mode_btn),
    .Inc_btn   (Inc_btn),
    .Dec_btn   (Dec_btn),
    .Time_now  (Time_now),
    .Tick      (Tick),
    .Load      (Load),
    .Time_load (Time_load),
    .Edit_field(Edit_field),
    .Blank_mask(Blank_mask)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [23:0] got,
                     input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic btn(input bit m, input bit i, input bit d);
    Mode_btn = m;
    Inc_btn  = i;
    Dec_btn  = d;
    step(1);
    Mode_btn = 1'b0;
    Inc_btn  = 1'b0;
    Dec_btn  = 1'b0;
    step(1);
  endtask

  task automatic commit(input logic [23:0] e);
    exp_q.push_back(e);
    btn(1, 0, 0);
    chk("field after commit", 24'(Edit_field), 24'd0);
    step(5);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!Tick && n < 20) begin
      step(1);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL wait_tick: got no Tick want Tick within 20 cycles");
    end
  endtask

  // Monitor: tick gating, blank mask, Load scoreboard, post-load tick
  always @(negedge CLK) begin
    checks++;
    if (Tick && (Edit_field != 2'd0 || Load)) begin
      errors++;
      $display("FAIL tick_gate: got Tick=1 field=%0d load=%0b want Tick=0",
               Edit_field, Load);
    end
`ifdef CLOCK_SET_BLINK_EN
    if (Edit_field == 2'd0) begin
      checks++;
      if (Blank_mask !== 3'b000) begin
        errors++;
        $display("FAIL blank_idle: got %b want 000", Blank_mask);
      end
    end
`else
    checks++;
    if (Blank_mask !== 3'b000) begin
      errors++;
      $display("FAIL blank_tied: got %b want 000", Blank_mask);
    end
`endif
    if (Load) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load: got unexpected Load Time_load=%h want none",
                 Time_load);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if (Time_load !== e) begin
          errors++;
          $display("FAIL time_load: got %h want %h", Time_load, e);
        end
      end
      load_cyc  = cyc;
      load_pend = 1'b1;
    end
    if (Tick && load_pend) begin
      checks++;
      if (cyc - load_cyc != 4) begin
        errors++;
        $display("FAIL tick_after_load: got %0d cycles want 4",
                 cyc - load_cyc);
      end
      load_pend = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 Reset = 1'b1;
    step(2);
    chk("rst Tick", 24'(Tick), 24'd0);
    chk("rst Load", 24'(Load), 24'd0);
    chk("rst Time_load", Time_load, 24'h000000);
    chk("rst Edit_field", 24'(Edit_field), 24'd0);
    chk("rst Blank_mask", 24'(Blank_mask), 24'd0);
    Reset = 1'b0;
    step(2);

    // Tick period in RUN
    wait_tick(n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!Tick && n < 20);
    chk("tick period", 24'(n), 24'd4);

    // Main set sequence 12:34:56 -> 15:32:56
    Time_now = 24'h123456;
    btn(1, 0, 0);
    chk("set field H", 24'(Edit_field), 24'd1);
    repeat (3) btn(0, 1, 0);
    btn(1, 0, 0);
    chk("set field M", 24'(Edit_field), 24'd2);
    repeat (2) btn(0, 0, 1);
    btn(1, 0, 0);
    chk("set field S", 24'(Edit_field), 24'd3);
    commit(24'h153256);

    // Wrap-around: 23->00, 00->59, 59->00
    Time_now = 24'h230059;
    btn(1, 0, 0);
    btn(0, 1, 0);
    btn(1, 0, 0);
    btn(0, 0, 1);
    btn(1, 0, 0);
    btn(0, 1, 0);
    commit(24'h005900);

    // Carry/borrow: hours 09->10, minutes 10->09
    Time_now = 24'h091000;
    btn(1, 0, 0);
    btn(0, 1, 0);
    btn(1, 0, 0);
    btn(0, 0, 1);
    btn(1, 0, 0);
    commit(24'h100900);

    // Timeout, Mode edge aligned to an internal second
    wait_tick(n);
    step(3);
    Mode_btn = 1'b1;
    step(1);
    chk("timeout enter", 24'(Edit_field), 24'd1);
    step(7);
    chk("timeout cycle 7", 24'(Edit_field), 24'd1);
    step(1);
    chk("timeout cycle 8", 24'(Edit_field), 24'd0);
    step(6);
    chk("held mode stays RUN", 24'(Edit_field), 24'd0);
    Mode_btn = 1'b0;
    step(2);

    // Conflicts: Mode+Inc, then Inc+Dec
    Time_now = 24'h123456;
    btn(1, 0, 0);
    btn(1, 1, 0);
    chk("mode+inc advances", 24'(Edit_field), 24'd2);
    btn(0, 1, 1);
    chk("inc+dec stays", 24'(Edit_field), 24'd2);
    btn(1, 0, 0);
    commit(24'h123456);

    // Blink in SET_M
    Time_now = 24'h000000;
    btn(1, 0, 0);
    Mode_btn = 1'b1;
    step(1);
    Mode_btn = 1'b0;
    step(1);
    chk("blink k+1", 24'(Blank_mask), 24'd0);
    step(1);
    chk("blink k+2", 24'(Blank_mask), BL ? 24'h2 : 24'h0);
    Inc_btn = 1'b1;
    step(1);
    chk("blink inc force", 24'(Blank_mask), 24'd0);
    Inc_btn = 1'b0;
    step(1);
    chk("blink k+4", 24'(Blank_mask), 24'd0);
    step(1);
    chk("blink k+5", 24'(Blank_mask), BL ? 24'h2 : 24'h0);
    btn(1, 0, 0);
    commit(24'h000100);

    // Reset asserted mid-edit in SET_M
    Time_now = 24'h112233;
    btn(1, 0, 0);
    btn(1, 0, 0);
    btn(0, 1, 0);
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("midrst Tick", 24'(Tick), 24'd0);
    chk("midrst Load", 24'(Load), 24'd0);
    chk("midrst Time_load", Time_load, 24'h000000);
    chk("midrst Edit_field", 24'(Edit_field), 24'd0);
    chk("midrst Blank_mask", 24'(Blank_mask), 24'd0);
    step(2);
    Reset = 1'b0;
    step(3);
    chk("after midrst field", 24'(Edit_field), 24'd0);

    chk("scoreboard drained", 24'(exp_q.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
